// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder.
// Contents: FSM state encoding, word and counter widths, alignment mask.
// The optional alignment check is enabled by defining DM_ALIGN_CHECK_EN.
package dm_pkg;

  localparam int unsigned DM_WORD_W = 32;
  localparam int unsigned DM_CNT_W  = 4;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_e;

endpackage

// File: rtl/dm_word_ram.sv
// Word array backing the data-memory responder.
// Ports:
//   clk      clock, write on rising edge
//   we_i     write enable
//   widx_i   write word index
//   wdata_i  write data
//   ridx_i   read word index (asynchronous read)
//   rdata_o  read data
module dm_word_ram
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [IDX_W-1:0]     widx_i,
  input  logic [DM_WORD_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]     ridx_i,
  output logic [DM_WORD_W-1:0] rdata_o
);

  logic [DM_WORD_W-1:0] mem_q [DEPTH_WORDS];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/dm_responder.sv
// Memory-side responder for the data-memory port: one outstanding load/store,
// fixed response latency, valid/ready on both request and response.
// Ports:
//   clk, INT_n              clock, synchronous active-low reset
//   req_valid/req_ready     request handshake (req_ready high only in IDLE, out of reset)
//   req_we/addr/wdata       request payload, latched on acceptance
//   rsp_valid/rsp_ready     response handshake, response held until consumed
//   rsp_rdata/rsp_err       load data (0 for stores/errors) and alignment error
//   busy                    high in WAIT or RESP
// Optional feature: define DM_ALIGN_CHECK_EN to reject misaligned addresses.
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        INT_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned ADDR_W = IDX_W + 2;
  localparam bit          LAT1   = (LATENCY == 1);
  localparam logic [DM_CNT_W-1:0] CNT_INIT =
    DM_CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  dm_state_e              state_q;
  logic [DM_CNT_W-1:0]    cnt_q;
  logic                   we_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DM_WORD_W-1:0]   wdata_q;
  logic                   rsp_valid_q;
  logic [DM_WORD_W-1:0]   rsp_rdata_q;
  logic                   rsp_err_q;
  logic                   busy_q;

  logic                   cur_we;
  logic [ADDR_W-1:0]      cur_addr;
  logic [DM_WORD_W-1:0]   cur_wdata;
  logic                   cur_err;
  logic                   go_resp;
  logic                   ram_we;
  logic [DM_WORD_W-1:0]   ram_rdata;
  logic                   unused_bits;

  // With LATENCY=1 the RESP entry edge is the accept edge, so the live
  // request feeds the datapath in IDLE; otherwise the latched copy does.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr[ADDR_W-1:0];
      cur_wdata = req_wdata;
    end
  end

`ifdef DM_ALIGN_CHECK_EN
  assign cur_err     = (cur_addr[1:0] & ALIGN_MASK) != 2'b00;
  assign unused_bits = ^req_addr[31:ADDR_W];
`else
  assign cur_err     = 1'b0;
  assign unused_bits = ^{req_addr[31:ADDR_W], cur_addr[1:0]};
`endif

  // Edge on which the request completes (store commit / load capture).
  always_comb begin
    go_resp = 1'b0;
    if (INT_n) begin
      if (state_q == IDLE) begin
        go_resp = LAT1 && req_valid;
      end else if (state_q == WAIT) begin
        go_resp = (cnt_q == '0);
      end
    end
  end

  assign ram_we = go_resp && cur_we && !cur_err;

  dm_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .widx_i  (cur_addr[ADDR_W-1:2]),
    .wdata_i (cur_wdata),
    .ridx_i  (cur_addr[ADDR_W-1:2]),
    .rdata_o (ram_rdata)
  );

  // FSM, latency counter, request latches and response registers.
  always_ff @(posedge clk) begin
    if (!INT_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr[ADDR_W-1:0];
            wdata_q <= req_wdata;
            busy_q  <= 1'b1;
            if (LAT1) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - DM_CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (go_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= cur_err;
        rsp_rdata_q <= (cur_we || cur_err) ? '0 : ram_rdata;
      end
    end
  end

  assign req_ready = (state_q == IDLE) && INT_n;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a vector table of load/store transactions
// plus hand-written sequences for reset, backpressure and reset during WAIT.
module tb_dm_responder;

  localparam int unsigned DEPTH_WORDS = 64;
  localparam int unsigned LATENCY     = 2;

  logic        clk = 1'b0;
  logic        INT_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  dm_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .LATENCY     (LATENCY)
  ) dut (
    .clk       (clk),
    .INT_n     (INT_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One full transaction; response held for 'hold' cycles before consuming.
  task automatic transact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, output logic [31:0] rdata, output logic err);
    int lat;
    bit seen;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    // Scramble the payload: the responder must have latched it.
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      check("req_ready_wait", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    check("rsp_seen", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'(LATENCY));
    check("busy_resp", 32'(busy), 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, rdata);
      check("hold_err", 32'(rsp_err), 32'(err));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("busy_drop", 32'(busy), 32'd0);
    check("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  vec_t        vecs [11];
  logic [31:0] rd;
  logic        er;

  initial begin
`ifdef DM_ALIGN_CHECK_EN
    vecs[7]  = '{1'b1, 32'h0000_0029, 32'h0000_0055, 32'h0,         1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0028, 32'h0,         32'hDEADBEEF,  1'b0};
    vecs[9]  = '{1'b0, 32'h0000_002B, 32'h0,         32'h0,         1'b1};
`else
    vecs[7]  = '{1'b1, 32'h0000_0029, 32'h0000_0055, 32'h0,         1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0028, 32'h0,         32'h0000_0055, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_002B, 32'h0,         32'h0000_0055, 1'b0};
`endif
    vecs[0]  = '{1'b1, 32'h0000_0028, 32'hDEADBEEF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0028, 32'h0,        32'hDEADBEEF,  1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0000, 32'h0000_0011, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0100, 32'h0,        32'h0000_0011, 1'b0};
    vecs[4]  = '{1'b0, 32'hFFFF_FF28, 32'h0,        32'hDEADBEEF,  1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0030, 32'h0000_A5A5, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0030, 32'h0,        32'h0000_A5A5, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_00FC, 32'h0000_1234, 32'h0,        1'b0};

    INT_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    // Reset for two cycles.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    INT_n = 1'b1;
    #1;
    check("rel_req_ready", 32'(req_ready), 32'd1);

    // Table of transactions, fully consumed immediately.
    for (int i = 0; i < 11; i++) begin
      transact(vecs[i].we, vecs[i].addr, vecs[i].wdata, 0, rd, er);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end
    transact(1'b0, 32'h0000_01FC, 32'h0, 0, rd, er);
    check("last_word_wrap", rd, 32'h0000_1234);

    // Backpressure: response held five cycles.
    transact(1'b0, 32'h0000_0100, 32'h0, 5, rd, er);
    check("bp_rdata", rd, 32'h0000_0011);

    // Reset while the store is still in WAIT.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0000_0030;
    req_wdata = 32'h0000_0077;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    INT_n     = 1'b0;
    check("wait_busy", 32'(busy), 32'd1);
    check("wait_rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("wait_rst_valid", 32'(rsp_valid), 32'd0);
    check("wait_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    INT_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
    end
    transact(1'b0, 32'h0000_0030, 32'h0, 0, rd, er);
    check("lost_store", rd, 32'h0000_A5A5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
